instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the 16-bit Harvard core. Owns the program counter, drives the word address of the combinational instruction memory, and captures the returned 32-bit instruction into a registered fetch/decode output with a valid/ready handshake. Supports stall from decode, PC redirect with flush for branches and jumps, and optional halt detection.

## Interface
- PC_W, 6: program counter / instruction memory address width.
- INSTR_W, 32: instruction word width.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_W  address to instruction memory; equals current PC (combinational from PC register).
- imem_data  in  INSTR_W  instruction word from memory, valid in the same cycle as imem_addr.
- fetch_en  in  1  permits new fetches when high.
- redirect_valid  in  1  one-cycle request to load redirect_pc and flush.
- redirect_pc  in  PC_W  target PC for redirect.
- out_valid  out  1  out_instr/out_pc hold a valid fetched instruction.
- out_ready  in  1  decode accepts the output this cycle.
- out_instr  out  INSTR_W  registered instruction.
- out_pc  out  PC_W  address the registered instruction was fetched from.
- halted  out  1  fetch has stopped on a halt word (tied 0 when feature compiled out).

## Operation
- FSM states: RUN, HALTED. Reset state RUN.
- Capture condition (cap): state RUN, fetch_en=1, redirect_valid=0, and (out_valid=0 or out_ready=1).
- Priority per cycle: redirect > capture > drain > hold.
- Redirect: PC <= redirect_pc; out_valid <= 0 (in-flight instruction discarded even if out_ready=1); state <= RUN.
- Capture: out_instr <= imem_data; out_pc <= PC; out_valid <= 1; PC <= PC+1 modulo 2^PC_W (2^PC_W-1 wraps to 0).
- Drain: no capture but out_valid=1 and out_ready=1 -> out_valid <= 0.
- Hold: out_valid=1, out_ready=0 -> out_instr, out_pc, PC unchanged.
- fetch_en=0: PC frozen; existing output may still drain.
- HALTED: no captures; PC frozen; output drains normally; exit only by redirect or reset.

## Timing
- Reset values: PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, state RUN. imem_addr=RESET_PC immediately on reset assertion.
- Latency: instruction at PC appears on out_instr one cycle after PC is presented.
- Throughput: one instruction per cycle while out_ready=1 and fetch_en=1.
- out_instr/out_pc must not change while out_valid=1 and out_ready=0.
- Redirect takes effect next edge: next cycle imem_addr=redirect_pc, out_valid=0; first target instruction valid one cycle later.
- Reset asserted mid-operation: all state returns to reset values asynchronously; pending output lost.

## Configuration
- FETCH_HALT_DETECT_EN defined: when cap would capture imem_data equal to all-zero (HALT_WORD, the memory's out-of-range default), nothing is captured, out_valid <= 0 (or drains per rules), PC holds at the halt address, state <= HALTED, halted=1 from next cycle until redirect/reset.
- Not defined: all-zero word fetched as an ordinary instruction; HALTED never entered; halted constant 0.

## Structure
- Shared package fetch_pkg: PC_W, INSTR_W, RESET_PC defaults, HALT_WORD constant, fetch state enum (RUN, HALTED).
- One sub-module: fetch_pc_counter (PC register with load/increment/hold, async reset, wrap). Handshake register and FSM in the top.

## Test plan
- Reset, fetch_en=1, out_ready=1, memory words 0x00200005, 0x00E00001, 0x10640027 at 0..2 -> out_pc 0,1,2 on cycles 1,2,3 with matching out_instr, out_valid=1 each.
- out_ready=0 for 3 cycles while out_valid=1 at PC 1 -> out_instr/out_pc frozen, imem_addr stays 2; release -> resumes at 2 with no loss or duplicate.
- redirect_valid with redirect_pc=40 while out_valid=1, out_ready=1 -> next cycle out_valid=0, imem_addr=40; following cycle out_pc=40.
- PC at 63, continuous fetch -> next imem_addr=0, out_pc sequence 63,0.
- Macro on: word at address 3 is 0 -> outputs for 0..2 only, halted=1, imem_addr held at 3; redirect to 0 clears halted, refetches 0. Macro off: out_instr=0 delivered with out_pc=3, halted=0.
- Assert rst asynchronously mid-stream -> out_valid=0, imem_addr=0 before next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, the
// reset PC, the halt word and the fetch state encoding.
package fetch_pkg;

  localparam int DEFAULT_PC_W     = 6;
  localparam int DEFAULT_INSTR_W  = 32;
  localparam int DEFAULT_RESET_PC = 0;

  // The instruction memory returns all zeros for out-of-range addresses,
  // so an all-zero word doubles as the halt marker when halt detection is on.
  localparam logic [DEFAULT_INSTR_W-1:0] HALT_WORD = '0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // True when the fetched word is the halt marker.
  function automatic logic isHaltWord(input logic [DEFAULT_INSTR_W-1:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch stage, the instruction memory and decode.
// The master side is the fetch unit; the slave side is memory plus decode.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEFAULT_PC_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_pc_counter.sv
// Program counter register: load wins over increment, otherwise hold.
// Incrementing past the top address wraps naturally to zero.
module fetch_pc_counter
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [PC_W-1:0] loadPc_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pcQ;
  logic [PC_W-1:0] pcD;

  // Next PC: redirect target, sequential successor, or unchanged.
  always_comb begin
    pcD = pcQ;
    if (load_i) begin
      pcD = loadPc_i;
    end else if (inc_i) begin
      pcD = pcQ + PC_W'(1);
    end
  end

  // PC register, returns to the reset PC immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcQ <= RESET_PC;
    end else begin
      pcQ <= pcD;
    end
  end

  assign pc_o = pcQ;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory address from the PC
// and registers the returned word for decode behind a valid/ready handshake.
// Redirects flush the output register and reload the PC.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter int              INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en_i,
  input  logic               redirect_valid_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               halted_o,
  instr_fetch_unit_if.master bus
);

  logic [PC_W-1:0]    pcQ;
  fetch_state_e       stateQ;
  logic               outValidQ;
  logic [INSTR_W-1:0] outInstrQ;
  logic [PC_W-1:0]    outPcQ;

  logic canAccept;
  logic capReq;
  logic haltHit;
  logic capture;

  // Program counter: redirect loads the target, a real capture advances it.
  fetch_pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load_i   (redirect_valid_i),
    .loadPc_i (redirect_pc_i),
    .inc_i    (capture),
    .pc_o     (pcQ)
  );

  // Capture qualification; a halt word suppresses the capture itself.
  always_comb begin
    canAccept = !outValidQ || bus.out_ready;
    capReq    = (stateQ == RUN) && fetch_en_i && !redirect_valid_i && canAccept;
`ifdef FETCH_HALT_DETECT_EN
    haltHit   = capReq && isHaltWord(bus.imem_data);
`else
    haltHit   = 1'b0;
`endif
    capture   = capReq && !haltHit;
  end

  // Handshake register and run/halt FSM: redirect > capture > drain > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= RUN;
      outValidQ <= 1'b0;
      outInstrQ <= '0;
      outPcQ    <= '0;
    end else if (redirect_valid_i) begin
      stateQ    <= RUN;
      outValidQ <= 1'b0;
    end else if (capture) begin
      outValidQ <= 1'b1;
      outInstrQ <= bus.imem_data;
      outPcQ    <= pcQ;
    end else begin
      if (outValidQ && bus.out_ready) begin
        outValidQ <= 1'b0;
      end
      if (haltHit) begin
        stateQ <= HALTED;
      end
    end
  end

  assign bus.imem_addr = pcQ;
  assign bus.out_valid = outValidQ;
  assign bus.out_instr = outInstrQ;
  assign bus.out_pc    = outPcQ;

`ifdef FETCH_HALT_DETECT_EN
  assign halted_o = (stateQ == HALTED);
`else
  assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: a table of per-cycle stimulus
// with expected outputs, plus a hand-written asynchronous reset sequence.
// Expectations follow FETCH_HALT_DETECT_EN when it is defined.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic        fetchEn;
    logic        redirValid;
    logic [5:0]  redirPc;
    logic        outReady;
    logic        expValid;
    logic [5:0]  expPc;
    logic [31:0] expInstr;
    logic [5:0]  expAddr;
    logic        expHalted;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       fetchEn;
  logic       redirValid;
  logic [5:0] redirPc;
  logic       halted;

  logic [31:0] mem [64];
  vec_t        vecs [$];

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en_i       (fetchEn),
    .redirect_valid_i (redirValid),
    .redirect_pc_i    (redirPc),
    .halted_o         (halted),
    .bus              (bus.master)
  );

  // Combinational instruction memory model.
  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: three real instructions, a zero word at 3, tagged words elsewhere.
  function automatic logic [31:0] memWord(input int addr);
    case (addr)
      0:       return 32'h0020_0005;
      1:       return 32'h00E0_0001;
      2:       return 32'h1064_0027;
      3:       return 32'h0000_0000;
      default: return 32'hA000_0000 | 32'(addr);
    endcase
  endfunction

  function automatic vec_t mkVec(input logic fe, input logic rv, input logic [5:0] rpc,
                                 input logic rdy, input logic ev, input logic [5:0] epc,
                                 input logic [31:0] ei, input logic [5:0] ea, input logic eh);
    vec_t v;
    v.fetchEn    = fe;
    v.redirValid = rv;
    v.redirPc    = rpc;
    v.outReady   = rdy;
    v.expValid   = ev;
    v.expPc      = epc;
    v.expInstr   = ei;
    v.expAddr    = ea;
    v.expHalted  = eh;
    return v;
  endfunction

  task automatic applyStimulus(input logic fe, input logic rv, input logic [5:0] rpc,
                               input logic rdy);
    fetchEn       = fe;
    redirValid    = rv;
    redirPc       = rpc;
    bus.out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic [5:0] epc,
                          input logic [31:0] ei, input logic [5:0] ea, input logic eh);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
    checkOutput({tag, " out_pc"},    32'(bus.out_pc),    32'(epc));
    checkOutput({tag, " out_instr"}, bus.out_instr,      ei);
    checkOutput({tag, " imem_addr"}, 32'(bus.imem_addr), 32'(ea));
    checkOutput({tag, " halted"},    32'(halted),        32'(eh));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = memWord(i);

    // Stall at PC 1 for three cycles, then halt/zero word at 3, redirects, wrap at 63.
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 0,  memWord(0),  1,  0));
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 1,  memWord(1),  2,  0));
    vecs.push_back(mkVec(1, 0, 0,  0, 1, 1,  memWord(1),  2,  0));
    vecs.push_back(mkVec(1, 0, 0,  0, 1, 1,  memWord(1),  2,  0));
    vecs.push_back(mkVec(1, 0, 0,  0, 1, 1,  memWord(1),  2,  0));
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 2,  memWord(2),  3,  0));
`ifdef FETCH_HALT_DETECT_EN
    vecs.push_back(mkVec(1, 0, 0,  1, 0, 2,  memWord(2),  3,  1));
    vecs.push_back(mkVec(1, 1, 40, 1, 0, 2,  memWord(2),  40, 0));
`else
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 3,  32'h0,       4,  0));
    vecs.push_back(mkVec(1, 1, 40, 1, 0, 3,  32'h0,       40, 0));
`endif
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 40, memWord(40), 41, 0));
    vecs.push_back(mkVec(0, 0, 0,  1, 0, 40, memWord(40), 41, 0));
    vecs.push_back(mkVec(0, 0, 0,  0, 0, 40, memWord(40), 41, 0));
    vecs.push_back(mkVec(1, 1, 63, 1, 0, 40, memWord(40), 63, 0));
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 63, memWord(63), 0,  0));
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 0,  memWord(0),  1,  0));
    vecs.push_back(mkVec(1, 1, 2,  0, 0, 0,  memWord(0),  2,  0));
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 2,  memWord(2),  3,  0));
`ifdef FETCH_HALT_DETECT_EN
    vecs.push_back(mkVec(1, 0, 0,  1, 0, 2,  memWord(2),  3,  1));
    vecs.push_back(mkVec(1, 0, 0,  1, 0, 2,  memWord(2),  3,  1));
    vecs.push_back(mkVec(1, 1, 0,  1, 0, 2,  memWord(2),  0,  0));
`else
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 3,  32'h0,       4,  0));
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 4,  memWord(4),  5,  0));
    vecs.push_back(mkVec(1, 1, 0,  1, 0, 4,  memWord(4),  0,  0));
`endif
    vecs.push_back(mkVec(1, 0, 0,  1, 1, 0,  memWord(0),  1,  0));

    // Reset state is visible while reset is still held.
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    #12;
    checkAll("reset", 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: inputs for one cycle, outputs checked just after the edge.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fetchEn, vecs[i].redirValid, vecs[i].redirPc, vecs[i].outReady);
      @(posedge clk);
      #1;
      checkAll($sformatf("row%0d", i), vecs[i].expValid, vecs[i].expPc,
               vecs[i].expInstr, vecs[i].expAddr, vecs[i].expHalted);
    end

    // Mid-stream asynchronous reset: state clears before the next clock edge.
    applyStimulus(1, 0, 0, 1);
    @(posedge clk);
    #1;
    checkAll("prereset", 1, 1, memWord(1), 2, 0);
    #2;
    rst = 1'b1;
    #1;
    checkAll("asyncreset", 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkAll("postreset", 1, 0, memWord(0), 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
